spi_master_gen: RTL and testbench

Parametrised SPI master for all four SPI modes, generalising the fixed 8-bit, single-slave master. Adds configurable word width, multiple chip selects, a runtime clock divider, LSB/MSB-first ordering and multi-word bursts with chip select held between words. Sits between a register/command front end (valid/ready request side) and the SPI pins.

---
 rtl/spi_master_gen.sv | 194 +++++++++++++++++++
 tb/tb_spi_master_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: all four modes, DATA_W-bit words, NUM_CS one-hot-low selects,
// runtime SCLK divider, LSB/MSB ordering and CS-held bursts. Define SPI_LOOPBACK_EN to add the loopback port.
module spi_master_gen #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        mode,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              lsb_first,
  input  logic              hold_cs,
  input  logic [DIV_W-1:0]  clk_div,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int EC_W = $clog2(2 * DATA_W + 2);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W);
  localparam logic [EC_W-1:0] FIN_EDGE  = EC_W'(2 * DATA_W + 1);

  typedef enum logic [1:0] {IDLE, XFER, GUARD, HELD} state_t;

  state_t            state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_lat;
  logic [EC_W-1:0]   edge_cnt;
  logic              cpol_lat;
  logic              cpha_lat;
  logic [CS_W-1:0]   cs_lat;
  logic              lsb_lat;
  logic              hold_lat;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (32'(sel) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic pick_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  logic              held;
  logic              accept;
  logic              acc_cpol;
  logic              acc_cpha;
  logic [CS_W-1:0]   acc_sel;
  logic              tick;
  logic [EC_W-1:0]   edge_nxt;
  logic              is_edge;
  logic              out_edge;
  logic              sample_edge;
  logic              fin;
  logic              sin;

  // Mode and slave stay frozen while CS is held between burst words.
  assign held     = (state == HELD);
  assign accept   = start && ready;
  assign acc_cpol = held ? cpol_lat : mode[1];
  assign acc_cpha = held ? cpha_lat : mode[0];
  assign acc_sel  = held ? cs_lat : cs_sel;

  assign tick        = (state == XFER) && (cnt == div_lat);
  assign edge_nxt    = edge_cnt + 1'b1;
  assign is_edge     = tick && (edge_nxt <= LAST_EDGE);
  assign out_edge    = is_edge && (edge_nxt[0] == cpha_lat);
  assign sample_edge = is_edge && (edge_nxt[0] != cpha_lat);
  assign fin         = tick && (edge_nxt == FIN_EDGE);

`ifdef SPI_LOOPBACK_EN
  logic lb_lat;
  assign sin = lb_lat ? mosi : miso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lb_lat <= 1'b0;
    else if (accept) lb_lat <= loopback;
  end
`else
  assign sin = miso;
`endif

  // Shift datapath: the CPHA=0 first bit leaves on acceptance, so the register is pre-shifted.
  always_ff @(posedge clk) begin
    if (accept)        tx_sh <= acc_cpha ? tx_data : shift_out(tx_data, lsb_first);
    else if (out_edge) tx_sh <= shift_out(tx_sh, lsb_lat);
    if (sample_edge)   rx_sh <= shift_in(rx_sh, sin, lsb_lat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      rx_data  <= '0;
      cnt      <= '0;
      div_lat  <= '0;
      edge_cnt <= '0;
      cpol_lat <= 1'b0;
      cpha_lat <= 1'b0;
      cs_lat   <= '0;
      lsb_lat  <= 1'b0;
      hold_lat <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, HELD: begin
          if (held) ready <= 1'b1;
          if (accept) begin
            state    <= XFER;
            ready    <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            edge_cnt <= '0;
            div_lat  <= clk_div;
            lsb_lat  <= lsb_first;
            hold_lat <= hold_cs;
            cpol_lat <= acc_cpol;
            cpha_lat <= acc_cpha;
            cs_lat   <= acc_sel;
            cs_n     <= ~cs_decode(acc_sel);
            sclk     <= acc_cpol;
            mosi     <= acc_cpha ? 1'b0 : pick_bit(tx_data, lsb_first);
          end
        end
        XFER: begin
          if (tick) begin
            cnt      <= '0;
            edge_cnt <= edge_nxt;
            if (is_edge)  sclk <= ~sclk;
            if (out_edge) mosi <= pick_bit(tx_sh, lsb_lat);
            // Final half-period at CPOL has elapsed: word complete.
            if (fin) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              rx_data <= rx_sh;
              mosi    <= 1'b0;
              if (hold_lat) begin
                state <= HELD;
              end else begin
                state <= GUARD;
                cs_n  <= '1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GUARD: begin
          if (cnt == div_lat) begin
            cnt   <= '0;
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: table of single-word transfers against a slave model,
// plus burst, reset, held-mode and 16-bit loopback sequences.
module tb_spi_master_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [7:0] tx_data;
  logic [1:0] mode;
  logic [1:0] cs_sel;
  logic       lsb_first;
  logic       hold_cs;
  logic [7:0] clk_div;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic [3:0] cs_n;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       loopback;

  logic        start16;
  logic        ready16;
  logic [15:0] tx16;
  logic [1:0]  mode16;
  logic [1:0]  sel16;
  logic        lsb16;
  logic        hold16;
  logic [7:0]  div16;
  logic        miso16;
  logic        sclk16;
  logic        mosi16;
  logic [2:0]  cs_n16;
  logic        busy16;
  logic        done16;
  logic [15:0] rx16;
  logic        lb16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_master_gen #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .tx_data(tx_data),
    .mode(mode), .cs_sel(cs_sel), .lsb_first(lsb_first), .hold_cs(hold_cs),
    .clk_div(clk_div),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done),
    .rx_data(rx_data)
  );

  spi_master_gen #(.DATA_W(16), .NUM_CS(3), .DIV_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .ready(ready16), .tx_data(tx16),
    .mode(mode16), .cs_sel(sel16), .lsb_first(lsb16), .hold_cs(hold16),
    .clk_div(div16),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb16),
`endif
    .miso(miso16), .sclk(sclk16), .mosi(mosi16), .cs_n(cs_n16), .busy(busy16),
    .done(done16), .rx_data(rx16)
  );

`ifdef SPI_LOOPBACK_EN
  assign miso16 = 1'b0;
`else
  assign miso16 = mosi16;
`endif

  // Slave model: MSB-first, reloads its word every 8 bits so bursts keep streaming.
  logic [7:0] sl_word;
  logic [7:0] sl_sh;
  logic [7:0] sl_rx;
  logic [1:0] sl_mode;
  int         sl_cnt;
  logic       sl_act_q;
  logic       sl_sclk_q;

  task automatic sl_shift();
    if (sl_cnt == 0) begin
      sl_sh  = sl_word;
      sl_cnt = 8;
    end
    miso   = sl_sh[7];
    sl_sh  = sl_sh << 1;
    sl_cnt = sl_cnt - 1;
  endtask

  always @(negedge clk) begin
    logic act;
    act = (cs_n != 4'hF);
    if (!act) begin
      sl_cnt = 0;
    end else if (!sl_act_q) begin
      sl_cnt = 0;
      if (!sl_mode[0]) sl_shift();
    end else if (sclk != sl_sclk_q) begin
      if ((sclk != sl_mode[1]) == sl_mode[0]) sl_shift();
      else sl_rx = {sl_rx[6:0], mosi};
    end
    sl_act_q  = act;
    sl_sclk_q = sclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [1:0] m, input logic [7:0] tx, input logic [1:0] sel,
                      input logic [1:0] mon, input logic lsb, input logic hold,
                      input logic [7:0] div, input logic keep,
                      output int done_n, output int edges, output int edge_err,
                      output int cs_hi, output logic sclk1, output logic mosi1,
                      output logic [3:0] cs1, output logic busy1, output logic ready1);
    int   d;
    logic prev;
    d = int'(div) + 1;
    mode = m; tx_data = tx; cs_sel = sel; lsb_first = lsb; hold_cs = hold; clk_div = div;
    start = 1'b1;
    tick();
    if (!keep) start = 1'b0;
    done_n = 1; edges = 0; edge_err = 0; cs_hi = 0;
    sclk1 = sclk; mosi1 = mosi; cs1 = cs_n; busy1 = busy; ready1 = ready;
    prev = sclk;
    while (!done && done_n < 5000) begin
      if (cs_n[mon]) cs_hi++;
      tick();
      done_n++;
      if (sclk !== prev) begin
        edges++;
        if (done_n != 1 + edges * d) edge_err++;
        prev = sclk;
      end
    end
  endtask

  typedef struct {
    logic [1:0] m;
    logic [7:0] tx;
    logic [7:0] sw;
    logic [1:0] sel;
    logic       lsb;
    logic [7:0] div;
    int         exp_done;
    logic [7:0] exp_rx;
    logic [7:0] exp_srx;
    logic [3:0] exp_cs;
    logic       exp_mosi1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   dn, ed, ee, ch, g, n, e, bad;
    logic s1, m1, b1, r1, prev;
    logic [3:0] c1;
    logic [7:0] bw[3];

    rst_n = 1'b0; start = 1'b0; tx_data = '0; mode = '0; cs_sel = '0; lsb_first = 1'b0;
    hold_cs = 1'b0; clk_div = '0; miso = 1'b0; loopback = 1'b0;
    start16 = 1'b0; tx16 = '0; mode16 = '0; sel16 = '0; lsb16 = 1'b0; hold16 = 1'b0;
    div16 = '0; lb16 = 1'b1;
    sl_word = '0; sl_sh = '0; sl_rx = '0; sl_mode = '0; sl_cnt = 0;
    sl_act_q = 1'b0; sl_sclk_q = 1'b0;

    vecs[0] = '{2'd0, 8'hA5, 8'h3C, 2'd0, 1'b0, 8'd1, 35, 8'h3C, 8'hA5, 4'hE, 1'b1};
    vecs[1] = '{2'd1, 8'h81, 8'h5A, 2'd1, 1'b0, 8'd0, 18, 8'h5A, 8'h81, 4'hD, 1'b0};
    vecs[2] = '{2'd2, 8'h81, 8'hC3, 2'd2, 1'b0, 8'd2, 52, 8'hC3, 8'h81, 4'hB, 1'b1};
    vecs[3] = '{2'd3, 8'h81, 8'h96, 2'd3, 1'b0, 8'd1, 35, 8'h96, 8'h81, 4'h7, 1'b0};
    vecs[4] = '{2'd0, 8'h01, 8'h12, 2'd0, 1'b1, 8'd0, 18, 8'h48, 8'h80, 4'hE, 1'b1};

    tick(); tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      sl_mode = vecs[i].m;
      sl_word = vecs[i].sw;
      xfer(vecs[i].m, vecs[i].tx, vecs[i].sel, vecs[i].sel, vecs[i].lsb, 1'b0, vecs[i].div,
           1'b0, dn, ed, ee, ch, s1, m1, c1, b1, r1);
      chk($sformatf("v%0d_cs1", i), 32'(c1), 32'(vecs[i].exp_cs));
      chk($sformatf("v%0d_busy1", i), 32'(b1), 32'd1);
      chk($sformatf("v%0d_ready1", i), 32'(r1), 32'd0);
      chk($sformatf("v%0d_sclk1", i), 32'(s1), 32'(vecs[i].m[1]));
      if (!vecs[i].m[0]) chk($sformatf("v%0d_mosi1", i), 32'(m1), 32'(vecs[i].exp_mosi1));
      chk($sformatf("v%0d_edges", i), 32'(ed), 32'd16);
      chk($sformatf("v%0d_edge_align", i), 32'(ee), 32'd0);
      chk($sformatf("v%0d_cs_gap", i), 32'(ch), 32'd0);
      chk($sformatf("v%0d_done_cyc", i), 32'(dn), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_rx", i), 32'(rx_data), 32'(vecs[i].exp_rx));
      chk($sformatf("v%0d_slave_rx", i), 32'(sl_rx), 32'(vecs[i].exp_srx));
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_cs_rel", i), 32'(cs_n), 32'hF);
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      g = 1;
      while (!ready && g < 100) begin tick(); g++; end
      chk($sformatf("v%0d_guard", i), 32'(g), 32'(int'(vecs[i].div) + 1));
      chk($sformatf("v%0d_idle_sclk", i), 32'(sclk), 32'(vecs[i].m[1]));
    end

    // Burst of three words to slave 2 with CS held between them.
    sl_mode = 2'd0; sl_word = 8'h5A;
    bw[0] = 8'h11; bw[1] = 8'h22; bw[2] = 8'h33;
    for (int w = 0; w < 3; w++) begin
      xfer(2'd0, bw[w], 2'd2, 2'd2, 1'b0, (w < 2), 8'd1, 1'b0, dn, ed, ee, ch, s1, m1, c1, b1, r1);
      chk($sformatf("burst%0d_cs1", w), 32'(c1), 32'hB);
      chk($sformatf("burst%0d_cs_gap", w), 32'(ch), 32'd0);
      chk($sformatf("burst%0d_edges", w), 32'(ed), 32'd16);
      chk($sformatf("burst%0d_done_cyc", w), 32'(dn), 32'd35);
      chk($sformatf("burst%0d_rx", w), 32'(rx_data), 32'h5A);
      chk($sformatf("burst%0d_slave_rx", w), 32'(sl_rx), 32'(bw[w]));
      if (w < 2) begin
        chk($sformatf("burst%0d_cs_held", w), 32'(cs_n), 32'hB);
        chk($sformatf("burst%0d_ready_done", w), 32'(ready), 32'd0);
        tick();
        chk($sformatf("burst%0d_ready_held", w), 32'(ready), 32'd1);
        chk($sformatf("burst%0d_cs_held2", w), 32'(cs_n), 32'hB);
      end else begin
        chk("burst_cs_rel", 32'(cs_n), 32'hF);
        g = 0;
        while (!ready && g < 100) begin
          if (cs_n != 4'hF) g = 1000;
          tick();
          g++;
        end
        chk("burst_guard", 32'(g), 32'd2);
      end
    end

    // Start held high while busy; mode/cs_sel change during HELD must be ignored.
    sl_mode = 2'd3; sl_word = 8'h69;
    xfer(2'd3, 8'hF0, 2'd1, 2'd1, 1'b0, 1'b1, 8'd0, 1'b1, dn, ed, ee, ch, s1, m1, c1, b1, r1);
    chk("hold_w1_done_cyc", 32'(dn), 32'd18);
    chk("hold_w1_edges", 32'(ed), 32'd16);
    chk("hold_w1_cs_gap", 32'(ch), 32'd0);
    chk("hold_w1_slave_rx", 32'(sl_rx), 32'hF0);
    start = 1'b0; mode = 2'd0; cs_sel = 2'd3;
    tick(); tick(); tick();
    chk("held_ready", 32'(ready), 32'd1);
    chk("held_busy", 32'(busy), 32'd0);
    chk("held_cs", 32'(cs_n), 32'hD);
    chk("held_sclk", 32'(sclk), 32'd1);
    xfer(2'd0, 8'h3C, 2'd3, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, dn, ed, ee, ch, s1, m1, c1, b1, r1);
    chk("hold_w2_cs1", 32'(c1), 32'hD);
    chk("hold_w2_sclk1", 32'(s1), 32'd1);
    chk("hold_w2_edge_align", 32'(ee), 32'd0);
    chk("hold_w2_done_cyc", 32'(dn), 32'd18);
    chk("hold_w2_rx", 32'(rx_data), 32'h69);
    chk("hold_w2_slave_rx", 32'(sl_rx), 32'h3C);
    g = 0;
    while (!ready && g < 100) begin tick(); g++; end
    chk("hold_w2_guard", 32'(g), 32'd1);

    // Reset at SCLK edge 5 of a mode-0 transfer.
    sl_mode = 2'd0; sl_word = 8'hA5;
    mode = 2'd0; tx_data = 8'hFF; cs_sel = 2'd0; lsb_first = 1'b0; hold_cs = 1'b0;
    clk_div = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1; e = 0; prev = sclk;
    while (e < 5 && n < 200) begin
      tick(); n++;
      if (sclk !== prev) begin e++; prev = sclk; end
    end
    chk("rstmid_edge5_cyc", 32'(n), 32'd11);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs_n", 32'(cs_n), 32'hF);
    chk("rstmid_sclk", 32'(sclk), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rx", 32'(rx_data), 32'd0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin tick(); if (done) bad++; end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); if (done) bad++; end
    chk("rstmid_no_done", 32'(bad), 32'd0);
    chk("rstmid_ready", 32'(ready), 32'd1);
    sl_word = 8'h5A;
    xfer(2'd0, 8'hC3, 2'd0, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0, dn, ed, ee, ch, s1, m1, c1, b1, r1);
    chk("rstmid_next_done_cyc", 32'(dn), 32'd35);
    chk("rstmid_next_rx", 32'(rx_data), 32'h5A);
    chk("rstmid_next_slave_rx", 32'(sl_rx), 32'hC3);
    g = 0;
    while (!ready && g < 100) begin tick(); g++; end

    // 16-bit LSB-first loopback, then an out-of-range select.
    tx16 = 16'h8001; lsb16 = 1'b1; sel16 = 2'd0; mode16 = 2'd0; div16 = 8'd0; hold16 = 1'b0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("w16_mosi1", 32'(mosi16), 32'd1);
    chk("w16_cs1", 32'(cs_n16), 32'h6);
    n = 1;
    while (!done16 && n < 5000) begin tick(); n++; end
    chk("w16_done_cyc", 32'(n), 32'd34);
    chk("w16_rx", 32'(rx16), 32'h8001);
    g = 0;
    while (!ready16 && g < 100) begin tick(); g++; end
    chk("w16_guard", 32'(g), 32'd1);
    tx16 = 16'h1234; lsb16 = 1'b0; sel16 = 2'd3;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n = 1; bad = 0;
    while (!done16 && n < 5000) begin
      if (cs_n16 != 3'b111) bad++;
      tick(); n++;
    end
    chk("w16_oor_cs", 32'(bad), 32'd0);
    chk("w16_oor_done_cyc", 32'(n), 32'd34);
    chk("w16_oor_rx", 32'(rx16), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
